wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//   Shares the single register-file write port between the pipeline writeback path and a
//   long-latency unit (mul/div, returning load). LL results are parked in a 1-entry buffer.
//   The buffer drains on free write-port cycles. After STARVE_MAX blocked cycles it freezes
//   writeback for one cycle and drains. Write-port outputs are registered, one stage as in WB.
// PARAMETERS
//   XLEN        32  data width of write-back results
//   AW          5   register index width
//   STARVE_MAX  4   blocked cycles tolerated before a forced drain (>=1)
// PORTS
//   clk          in   1     clock, all state on posedge
//   rst          in   1     asynchronous, active-high reset
//   pipe_we      in   1     pipeline WB write request
//   pipe_rd      in   AW    pipeline destination register
//   pipe_data    in   XLEN  pipeline write-back data
//   ll_valid     in   1     LL unit result valid
//   ll_rd        in   AW    LL destination register
//   ll_data      in   XLEN  LL result data
//   ll_ready     out  1     buffer accepts LL result this cycle (combinational)
//   ll_pending   out  1     buffer holds an unwritten LL result
//   stall_wb     out  1     freeze pipeline WB; upstream holds pipe_* stable
//   rf_we        out  1     register-file write enable (registered)
//   rf_rd        out  AW    register-file write index (registered)
//   rf_data      out  XLEN  register-file write data (registered)
// BEHAVIOUR
//   Reset: state=IDLE, buffer empty, starve_cnt=0, rf_we=0, rf_rd=0, rf_data=0, stall_wb=0, ll_pending=0.
//   Write-valid terms:
//     pipe_wr = pipe_we && pipe_rd!=0 && !stall_wb.
//     x0 writes never reach rf_we.
//   States:
//     IDLE  = buffer empty.
//     HOLD  = buffer full, waiting.
//     FORCE = buffer full, starved.
//   drain_now:
//     In HOLD, drain_now = !pipe_wr.
//     In FORCE, drain_now = 1.
//     In IDLE, drain_now = 0.
//   Capture:
//     ll_ready = (state==IDLE) || drain_now.
//     ll_valid && ll_rd==0 is accepted and discarded.
//     Otherwise ll_valid && ll_ready loads buf_rd/buf_data.
//     The next state is then HOLD with starve_cnt=0.
//   Write-port mux, registered, lands on rf_* one clock later:
//     pipe_wr wins. It drives rf_we=1, rf_rd=pipe_rd, rf_data=pipe_data.
//     Else drain_now drives rf_we=1, rf_rd=buf_rd, rf_data=buf_data.
//     Else rf_we=0, and rf_rd/rf_data hold their last value.
//   HOLD:
//     If pipe_wr: starve_cnt+1.
//       If pipe_rd==buf_rd, the buffer is invalidated (pipe is younger).
//       The next state is then IDLE.
//       Else, when starve_cnt reaches STARVE_MAX, go to FORCE.
//     If !pipe_wr: drain, then go to IDLE, or stay in HOLD on a same-cycle capture.
//   FORCE:
//     stall_wb=1, a Moore output of state==FORCE.
//     The pipe request is ignored this cycle and re-presented next cycle.
//     The buffer drains.
//     Next state is IDLE, or HOLD on a same-cycle capture. starve_cnt resets to 0.
//   Bounds:
//     stall_wb is high for exactly 1 cycle per forced drain.
//     At most one LL result is held.
//     When ll_ready=0, the LL unit must hold ll_valid and ll_rd/ll_data stable.
//   Mid-operation reset: the buffered result is discarded and stall_wb drops immediately.
//   No write is issued.
// TESTING
//   Reset: assert rst mid-HOLD -> rf_we=0, ll_pending=0, stall_wb=0, ll_ready=1 asynchronously.
//   Pipe only: pipe_we=1, rd=5, data=0xA5A5A5A5 -> next cycle rf_we=1, rf_rd=5, rf_data=0xA5A5A5A5.
//   x0 filter: pipe_rd=0, ll_rd=0 -> rf_we stays 0, ll_pending stays 0.
//   Idle drain: LL rd=7 captured, pipe idle next cycle -> rf_we=1, rf_rd=7 one cycle later.
//     ll_pending then clears.
//   Starvation (STARVE_MAX=4): LL rd=9 buffered, pipe writes rd=3 for 6 cycles.
//     -> 4 pipe writes, then stall_wb=1 for 1 cycle, rf_rd=9, then the held rd=3 write.
//   WAW and back-to-back:
//     Buffered rd=4 with pipe write rd=4 -> buffer dropped, single write 4.
//     A new ll_valid on the drain cycle is accepted (ll_ready=1) and ll_pending stays 1.

Source files
------------

// File: rtl/wb_port_arbiter_if.sv
// Write-port bundle shared by the pipeline writeback path, the long-latency unit
// and the register file write port.
interface wb_port_arbiter_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            pipe_we;
    logic [AW-1:0]   pipe_rd;
    logic [XLEN-1:0] pipe_data;
    logic            ll_valid;
    logic [AW-1:0]   ll_rd;
    logic [XLEN-1:0] ll_data;
    logic            ll_ready;
    logic            ll_pending;
    logic            stall_wb;
    logic            rf_we;
    logic [AW-1:0]   rf_rd;
    logic [XLEN-1:0] rf_data;

    modport slave (
        input  pipe_we, pipe_rd, pipe_data, ll_valid, ll_rd, ll_data,
        output ll_ready, ll_pending, stall_wb, rf_we, rf_rd, rf_data
    );

    modport master (
        output pipe_we, pipe_rd, pipe_data, ll_valid, ll_rd, ll_data,
        input  ll_ready, ll_pending, stall_wb, rf_we, rf_rd, rf_data
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback and a
// one-entry buffer of long-latency results, forcing a drain after STARVE_MAX blocked cycles.
module wb_port_arbiter #(
    parameter int XLEN       = 32,
    parameter int AW         = 5,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,
    wb_port_arbiter_if.slave   bus
);
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, HOLD, FORCE} arbState_e;

    arbState_e       stateReg;
    logic [CW-1:0]   starveCntReg;
    logic [AW-1:0]   bufRdReg;
    logic [XLEN-1:0] bufDataReg;
    logic            rfWeReg;
    logic [AW-1:0]   rfRdReg;
    logic [XLEN-1:0] rfDataReg;

    logic            pipeWr;
    logic            drainNow;
    logic            llReady;
    logic            llTake;
    logic [CW-1:0]   starveInc;

    always_comb begin
        // A FORCE cycle freezes writeback, so the pipe request is not a write then.
        pipeWr    = bus.pipe_we && (bus.pipe_rd != '0) && (stateReg != FORCE);
        drainNow  = 1'b0;
        case (stateReg)
            HOLD:    drainNow = !pipeWr;
            FORCE:   drainNow = 1'b1;
            default: drainNow = 1'b0;
        endcase
        llReady   = (stateReg == IDLE) || drainNow;
        // x0 results are acknowledged but never stored.
        llTake    = bus.ll_valid && llReady && (bus.ll_rd != '0);
        starveInc = starveCntReg + 1'b1;
    end

    assign bus.ll_ready   = llReady;
    assign bus.ll_pending = (stateReg != IDLE);
    assign bus.stall_wb   = (stateReg == FORCE);
    assign bus.rf_we      = rfWeReg;
    assign bus.rf_rd      = rfRdReg;
    assign bus.rf_data    = rfDataReg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg     <= IDLE;
            starveCntReg <= '0;
            bufRdReg     <= '0;
            bufDataReg   <= '0;
            rfWeReg      <= 1'b0;
            rfRdReg      <= '0;
            rfDataReg    <= '0;
        end else begin
            rfWeReg <= pipeWr || drainNow;
            if (pipeWr) begin
                rfRdReg   <= bus.pipe_rd;
                rfDataReg <= bus.pipe_data;
            end else if (drainNow) begin
                rfRdReg   <= bufRdReg;
                rfDataReg <= bufDataReg;
            end

            if (llTake) begin
                bufRdReg   <= bus.ll_rd;
                bufDataReg <= bus.ll_data;
            end

            case (stateReg)
                IDLE: begin
                    if (llTake) begin
                        stateReg     <= HOLD;
                        starveCntReg <= '0;
                    end
                end
                HOLD: begin
                    if (pipeWr) begin
                        starveCntReg <= starveInc;
                        // The pipe result is younger, so the buffered one is dead.
                        if (bus.pipe_rd == bufRdReg) begin
                            stateReg <= IDLE;
                        end else if (starveInc == STARVE_LIM) begin
                            stateReg <= FORCE;
                        end
                    end else begin
                        starveCntReg <= '0;
                        stateReg     <= llTake ? HOLD : IDLE;
                    end
                end
                FORCE: begin
                    starveCntReg <= '0;
                    stateReg     <= llTake ? HOLD : IDLE;
                end
                default: begin
                    stateReg     <= IDLE;
                    starveCntReg <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: expected register-file writes are queued as
// stimulus is applied and matched against rf_* as they appear.
module tb_wb_port_arbiter;
    logic clk;
    logic rst;

    wb_port_arbiter_if #(.XLEN(32), .AW(5)) bus ();

    wb_port_arbiter #(
        .XLEN(32),
        .AW(5),
        .STARVE_MAX(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wrExp_t;

    wrExp_t expQ[$];
    int testCnt;
    int failCnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        testCnt++;
        if (got !== exp) begin
            failCnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pushWr(input logic [4:0] rd, input logic [31:0] data);
        wrExp_t e;
        e.rd   = rd;
        e.data = data;
        expQ.push_back(e);
    endtask

    task automatic drive(input logic pwe, input logic [4:0] prd, input logic [31:0] pdata,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ldata);
        bus.pipe_we   = pwe;
        bus.pipe_rd   = prd;
        bus.pipe_data = pdata;
        bus.ll_valid  = lv;
        bus.ll_rd     = lrd;
        bus.ll_data   = ldata;
    endtask

    // Negedge sample: any rf write must be the oldest expected one.
    task automatic sample();
        wrExp_t e;
        @(negedge clk);
        if (bus.rf_we === 1'b1) begin
            checkEq("write_expected", 64'(expQ.size() != 0), 64'd1);
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                $display("[TB] write rd=%0d data=0x%08h (expect rd=%0d data=0x%08h)",
                         bus.rf_rd, bus.rf_data, e.rd, e.data);
                checkEq("wr_rd", 64'(bus.rf_rd), 64'(e.rd));
                checkEq("wr_data", 64'(bus.rf_data), 64'(e.data));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        for (int i = 0; i < n; i++) begin
            sample();
            tick();
        end
    endtask

    initial begin
        testCnt = 0;
        failCnt = 0;
        rst = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        sample();
        checkEq("rst_rf_we", 64'(bus.rf_we), 64'd0);
        checkEq("rst_rf_rd", 64'(bus.rf_rd), 64'd0);
        checkEq("rst_rf_data", 64'(bus.rf_data), 64'd0);
        checkEq("rst_pending", 64'(bus.ll_pending), 64'd0);
        checkEq("rst_stall", 64'(bus.stall_wb), 64'd0);
        checkEq("rst_ready", 64'(bus.ll_ready), 64'd1);
        tick();

        // Pipe only
        drive(1'b1, 5'd5, 32'hA5A5A5A5, 1'b0, 5'd0, 32'd0);
        pushWr(5'd5, 32'hA5A5A5A5);
        sample();
        tick();
        idleCycles(2);

        // x0 filter on both sources
        drive(1'b1, 5'd0, 32'h0BAD0000, 1'b1, 5'd0, 32'h0BAD0001);
        sample();
        checkEq("x0_ready", 64'(bus.ll_ready), 64'd1);
        tick();
        idleCycles(1);
        checkEq("x0_pending", 64'(bus.ll_pending), 64'd0);
        idleCycles(1);

        // Idle drain
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h00000777);
        pushWr(5'd7, 32'h00000777);
        sample();
        checkEq("drain_ready", 64'(bus.ll_ready), 64'd1);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        sample();
        checkEq("drain_pending_hold", 64'(bus.ll_pending), 64'd1);
        tick();
        sample();
        checkEq("drain_pending_clr", 64'(bus.ll_pending), 64'd0);
        checkEq("drain_rf_we", 64'(bus.rf_we), 64'd1);
        tick();
        idleCycles(1);

        // Starvation: four pipe writes, one forced drain, then the held pipe write
        pushWr(5'd3, 32'h31);
        pushWr(5'd3, 32'h32);
        pushWr(5'd3, 32'h33);
        pushWr(5'd3, 32'h34);
        pushWr(5'd9, 32'h99);
        pushWr(5'd3, 32'h35);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99);
        sample();
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd3, 32'h31 + 32'(i), 1'b0, 5'd0, 32'd0);
            sample();
            checkEq($sformatf("starve_nostall_%0d", i), 64'(bus.stall_wb), 64'd0);
            checkEq($sformatf("starve_pending_%0d", i), 64'(bus.ll_pending), 64'd1);
            tick();
        end
        drive(1'b1, 5'd3, 32'h35, 1'b0, 5'd0, 32'd0);
        sample();
        checkEq("starve_stall", 64'(bus.stall_wb), 64'd1);
        tick();
        sample();
        checkEq("starve_stall_drop", 64'(bus.stall_wb), 64'd0);
        checkEq("starve_pending_clr", 64'(bus.ll_pending), 64'd0);
        tick();
        idleCycles(2);

        // WAW: pipe write to the buffered register kills the buffered result
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h44);
        sample();
        tick();
        drive(1'b1, 5'd4, 32'h4A, 1'b0, 5'd0, 32'd0);
        pushWr(5'd4, 32'h4A);
        sample();
        checkEq("waw_ready", 64'(bus.ll_ready), 64'd0);
        tick();
        idleCycles(1);
        checkEq("waw_pending", 64'(bus.ll_pending), 64'd0);
        idleCycles(2);

        // Back-to-back capture on the drain cycle
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'hA0);
        pushWr(5'd10, 32'hA0);
        pushWr(5'd11, 32'hB0);
        sample();
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 32'hB0);
        sample();
        checkEq("b2b_ready", 64'(bus.ll_ready), 64'd1);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        sample();
        checkEq("b2b_pending", 64'(bus.ll_pending), 64'd1);
        tick();
        sample();
        checkEq("b2b_pending_clr", 64'(bus.ll_pending), 64'd0);
        tick();
        idleCycles(1);

        // Asynchronous reset while HOLD with a write on rf_*
        drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd12, 32'hC0);
        pushWr(5'd6, 32'h66);
        sample();
        tick();
        drive(1'b1, 5'd3, 32'h55, 1'b0, 5'd0, 32'd0);
        sample();
        checkEq("mrst_pending_pre", 64'(bus.ll_pending), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        checkEq("mrst_rf_we", 64'(bus.rf_we), 64'd0);
        checkEq("mrst_pending", 64'(bus.ll_pending), 64'd0);
        checkEq("mrst_stall", 64'(bus.stall_wb), 64'd0);
        checkEq("mrst_ready", 64'(bus.ll_ready), 64'd1);
        checkEq("mrst_rf_rd", 64'(bus.rf_rd), 64'd0);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        rst = 1'b0;
        idleCycles(3);
        checkEq("mrst_no_late_write", 64'(bus.rf_we), 64'd0);

        checkEq("scoreboard_empty", 64'(expQ.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end
endmodule
